// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with single-step and counted-burst operation
// Modes: hold, load, shift, rotate, arithmetic shift, sync clear. Bursts use start/busy/done.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;
  localparam logic [2:0] M_ASHR = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic [0:0]       state;
  logic [2:0]       op_r;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] q_step;

  // Bursts replay the latched op; single steps use the live mode input.
  assign step_op = (state == RUN) ? op_r : mode;

  always_comb begin
    q_step = q;
    case (step_op)
      M_HOLD:  q_step = q;
      M_LOAD:  q_step = d;
      M_SHL:   q_step = {q[WIDTH-2:0], sin_r};
      M_SHR:   q_step = {sin_l, q[WIDTH-1:1]};
      M_ROTL:  q_step = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ROTR:  q_step = {q[0], q[WIDTH-1:1]};
      M_ASHR:  q_step = {q[WIDTH-1], q[WIDTH-1:1]};
      M_CLR:   q_step = '0;
      default: q_step = q;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      op_r  <= M_HOLD;
      cnt   <= '0;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r <= mode;
            cnt  <= amount;
            if (amount != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else if (en) begin
            q <= q_step;
          end
        end
        RUN: begin
          q   <= q_step;
          cnt <= cnt - 1'b1;
          if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg
module tb_univ_shift_reg;
  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] d = 8'h00;
  logic       sin_r = 1'b0;
  logic       sin_l = 1'b0;
  logic       start = 1'b0;
  logic [3:0] amount = 4'd0;
  logic [7:0] q;
  logic       sout_msb, sout_lsb, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .start(start), .amount(amount),
    .q(q), .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    en = 1'b1; mode = 3'b001; d = v;
    tick();
    en = 1'b0; mode = 3'b000;
  endtask

  initial begin
    #2 clear = 1'b1;
    #10;
    check("reset_q", {24'd0, q}, 32'h00);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    clear = 1'b0;
    tick();

    // parallel load and hold
    en = 1'b1; mode = 3'b001; d = 8'hA5;
    tick();
    check("load_a5", {24'd0, q}, 32'hA5);
    mode = 3'b000;
    tick();
    check("hold_a5", {24'd0, q}, 32'hA5);
    en = 1'b0;

    // single-step rotates
    load(8'h81);
    en = 1'b1; mode = 3'b100;
    tick();
    check("rotl_81", {24'd0, q}, 32'h03);
    mode = 3'b101;
    tick();
    check("rotr_03", {24'd0, q}, 32'h81);
    tick();
    check("rotr_81", {24'd0, q}, 32'hC0);
    check("sout_lsb_c0", {31'd0, sout_lsb}, 32'd0);
    en = 1'b0;

    // ashr burst of 3; en asserted with start must be ignored
    load(8'h80);
    start = 1'b1; en = 1'b1; mode = 3'b110; amount = 4'd3;
    tick();
    start = 1'b0; en = 1'b0; mode = 3'b000;
    check("ashr_busy", {31'd0, busy}, 32'd1);
    check("ashr_q_first", {24'd0, q}, 32'h80);
    n = 0;
    while (busy && n < 20) begin n++; tick(); end
    check("ashr_cycles", n, 3);
    check("ashr_q", {24'd0, q}, 32'hF0);
    check("ashr_done", {31'd0, done}, 32'd1);
    tick();
    check("ashr_done_pulse", {31'd0, done}, 32'd0);

    // shl burst of 7
    load(8'h01);
    start = 1'b1; mode = 3'b010; amount = 4'd7; sin_r = 1'b0;
    tick();
    start = 1'b0; mode = 3'b000;
    n = 0;
    while (busy && n < 20) begin n++; tick(); end
    check("shl_cycles", n, 7);
    check("shl_q", {24'd0, q}, 32'h80);
    check("shl_msb", {31'd0, sout_msb}, 32'd1);
    check("shl_done", {31'd0, done}, 32'd1);

    // zero-length burst
    tick();
    start = 1'b1; mode = 3'b011; amount = 4'd0;
    tick();
    start = 1'b0; mode = 3'b000;
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_q", {24'd0, q}, 32'h80);
    tick();
    check("zero_done_pulse", {31'd0, done}, 32'd0);

    // shr burst of 10 aborted by clear after 4 steps; en during run ignored
    load(8'hFF);
    start = 1'b1; mode = 3'b011; amount = 4'd10; sin_l = 1'b0;
    tick();
    start = 1'b0; en = 1'b1; mode = 3'b001; d = 8'h5A;
    repeat (4) tick();
    check("abort_q_mid", {24'd0, q}, 32'h0F);
    check("abort_busy_mid", {31'd0, busy}, 32'd1);
    en = 1'b0; mode = 3'b000;
    clear = 1'b1;
    #1;
    check("abort_q", {24'd0, q}, 32'h00);
    check("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    clear = 1'b0;
    n = 0;
    repeat (8) begin tick(); if (done || busy) n++; end
    check("abort_no_done", n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
